mac_rx_monitor: RTL and testbench

//  Parametrised N-channel receive-frame monitor for the mac_rgmii RX logic-side streams.

---
 rtl/mac_rx_monitor.sv | 185 ++++++++++++++++++
 tb/tb_mac_rx_monitor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_monitor.sv
// Per-channel RX frame monitor: tracks framing and length, keeps saturating good/bad/byte/
// runt/giant/sequence counters, and exposes them through a one-cycle-latency read port.
module mac_rx_monitor #(
    parameter int CH_COUNT  = 4,
    parameter int CH_W      = 2,
    parameter int CNT_WIDTH = 32,
    parameter int LEN_W     = 16,
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*CH_COUNT-1:0] mac_rx_data,
    input  logic [CH_COUNT-1:0]   mac_rx_valid,
    input  logic [CH_COUNT-1:0]   mac_rx_sof,
    input  logic [CH_COUNT-1:0]   mac_rx_eof,
    input  logic [CH_COUNT-1:0]   mac_rx_fr_good,
    input  logic [CH_COUNT-1:0]   mac_rx_fr_err,
    input  logic                  clr,
    input  logic [CH_W-1:0]       rd_ch,
    input  logic [2:0]            rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic [CH_COUNT-1:0]   err_sticky,
    output logic                  err_det
);

    typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_e;

    localparam int C_GOOD  = 0;
    localparam int C_BAD   = 1;
    localparam int C_BYTES = 2;
    localparam int C_RUNT  = 3;
    localparam int C_GIANT = 4;
    localparam int C_SEQ   = 5;
    localparam int NUM_CNT = 6;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [LEN_W-1:0]     LEN_MAX = '1;
    localparam logic [LEN_W-1:0]     MIN_L   = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0]     MAX_L   = LEN_W'(MAX_FRAME);
    localparam int SUM_W = ((CNT_WIDTH > LEN_W + 1) ? CNT_WIDTH : LEN_W + 1) + 1;

    state_e               state_q [CH_COUNT];
    state_e               state_d [CH_COUNT];
    logic [LEN_W-1:0]     len_q   [CH_COUNT];
    logic [LEN_W-1:0]     len_d   [CH_COUNT];
    logic [CNT_WIDTH-1:0] cnt_q   [CH_COUNT][NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d   [CH_COUNT][NUM_CNT];
    logic [CH_COUNT-1:0]  bad_q, bad_d, sticky_q, sticky_d;
    logic                 err_det_q, err_any;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_mux;

    logic                 start, seq, end_a, ok_a, end_b, ok_b, ev;
    logic [LEN_W-1:0]     len_a, len_b;
    logic [1:0]           n_good, n_bad, n_runt, n_giant;
    logic                 unused_data;

    assign unused_data = ^mac_rx_data;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [LEN_W:0]       b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : s[CNT_WIDTH-1:0];
    endfunction

    function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] l);
        return (l == LEN_MAX) ? l : l + 1'b1;
    endfunction

    function automatic logic in_range(input logic [LEN_W-1:0] l);
        return (l >= MIN_L) && (l <= MAX_L);
    endfunction

    // A sof inside an open frame can close two frames in one beat: the aborted one (a)
    // and a 1-byte frame (b) that starts and ends on that same beat.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        bad_d    = bad_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        err_any  = 1'b0;
        start = 1'b0; seq = 1'b0; end_a = 1'b0; ok_a = 1'b0; end_b = 1'b0; ok_b = 1'b0;
        len_a = '0; len_b = '0; n_good = '0; n_bad = '0; n_runt = '0; n_giant = '0; ev = 1'b0;
        for (int c = 0; c < CH_COUNT; c++) begin
            start = 1'b0; seq = 1'b0; end_a = 1'b0; ok_a = 1'b0; end_b = 1'b0; ok_b = 1'b0;
            len_a = '0; len_b = '0;
            if (state_q[c] == FRAME) begin
                if (mac_rx_valid[c] && mac_rx_sof[c]) begin
                    seq   = 1'b1;
                    end_a = 1'b1;
                    len_a = len_q[c];
                    start = 1'b1;
                end else if (mac_rx_valid[c] && mac_rx_eof[c]) begin
                    end_a      = 1'b1;
                    len_a      = len_inc(len_q[c]);
                    ok_a       = mac_rx_fr_good[c] && !(bad_q[c] || mac_rx_fr_err[c]) && in_range(len_a);
                    state_d[c] = IDLE;
                end else begin
                    if (mac_rx_valid[c]) len_d[c] = len_inc(len_q[c]);
                    if (mac_rx_fr_err[c]) bad_d[c] = 1'b1;
                end
            end else if (mac_rx_valid[c] && mac_rx_sof[c]) begin
                start = 1'b1;
            end else if (mac_rx_valid[c] && mac_rx_eof[c]) begin
                seq = 1'b1;
            end

            if (start) begin
                if (mac_rx_eof[c]) begin
                    end_b      = 1'b1;
                    len_b      = LEN_W'(1);
                    ok_b       = mac_rx_fr_good[c] && !mac_rx_fr_err[c] && in_range(LEN_W'(1));
                    state_d[c] = IDLE;
                end else begin
                    state_d[c] = FRAME;
                    len_d[c]   = LEN_W'(1);
                    bad_d[c]   = mac_rx_fr_err[c];
                end
            end

            n_good  = 2'(ok_a) + 2'(ok_b);
            n_bad   = 2'(end_a && !ok_a) + 2'(end_b && !ok_b);
            n_runt  = 2'(end_a && (len_a < MIN_L)) + 2'(end_b && (len_b < MIN_L));
            n_giant = 2'(end_a && (len_a > MAX_L)) + 2'(end_b && (len_b > MAX_L));

            cnt_d[c][C_GOOD]  = sat_add(cnt_q[c][C_GOOD],  (LEN_W+1)'(n_good));
            cnt_d[c][C_BAD]   = sat_add(cnt_q[c][C_BAD],   (LEN_W+1)'(n_bad));
            cnt_d[c][C_BYTES] = sat_add(cnt_q[c][C_BYTES], (LEN_W+1)'(len_a) + (LEN_W+1)'(len_b));
            cnt_d[c][C_RUNT]  = sat_add(cnt_q[c][C_RUNT],  (LEN_W+1)'(n_runt));
            cnt_d[c][C_GIANT] = sat_add(cnt_q[c][C_GIANT], (LEN_W+1)'(n_giant));
            cnt_d[c][C_SEQ]   = sat_add(cnt_q[c][C_SEQ],   (LEN_W+1)'(seq));

            ev          = (n_bad != 2'd0) || seq;
            sticky_d[c] = sticky_q[c] | ev;
            err_any     = err_any | ev;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < CH_COUNT; c++) begin
            if (rd_ch == CH_W'(c)) begin
                case (rd_sel)
                    3'd0:    rd_mux = cnt_q[c][C_GOOD];
                    3'd1:    rd_mux = cnt_q[c][C_BAD];
                    3'd2:    rd_mux = cnt_q[c][C_BYTES];
                    3'd3:    rd_mux = cnt_q[c][C_RUNT];
                    3'd4:    rd_mux = cnt_q[c][C_GIANT];
                    3'd5:    rd_mux = cnt_q[c][C_SEQ];
                    3'd6:    rd_mux = CNT_WIDTH'({sticky_q[c], state_q[c] == FRAME});
                    default: rd_mux = '0;
                endcase
            end
        end
    end

    // NOTE: every register here is written with <= so all channels see pre-edge values.
    always_ff @(posedge clk) begin
        rd_data_q <= rst ? '0 : rd_mux;
        if (rst || clr) begin
            err_det_q <= 1'b0;
            sticky_q  <= '0;
            bad_q     <= '0;
            for (int c = 0; c < CH_COUNT; c++) begin
                state_q[c] <= IDLE;
                len_q[c]   <= '0;
                for (int k = 0; k < NUM_CNT; k++) cnt_q[c][k] <= '0;
            end
        end else begin
            err_det_q <= err_any;
            sticky_q  <= sticky_d;
            bad_q     <= bad_d;
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign err_sticky = sticky_q;
    assign err_det    = err_det_q;

endmodule

// File: tb/tb_mac_rx_monitor.sv
// Self-checking bench for mac_rx_monitor: directed frame scenarios checked against a
// constant table, then random multi-channel traffic checked against a frame-level model.
module tb_mac_rx_monitor;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst, clr;
    logic [8*CH-1:0] mac_rx_data;
    logic [CH-1:0] mac_rx_valid, mac_rx_sof, mac_rx_eof, mac_rx_fr_good, mac_rx_fr_err;
    logic [1:0]    rd_ch;
    logic [2:0]    rd_sel;
    logic [31:0]   rd_data;
    logic [CH-1:0] err_sticky;
    logic          err_det;
    logic [7:0]    rd_data8;
    logic [CH-1:0] err_sticky8;
    logic          err_det8;

    always #5 clk = ~clk;

    mac_rx_monitor u_dut (
        .clk(clk), .rst(rst), .mac_rx_data(mac_rx_data), .mac_rx_valid(mac_rx_valid),
        .mac_rx_sof(mac_rx_sof), .mac_rx_eof(mac_rx_eof), .mac_rx_fr_good(mac_rx_fr_good),
        .mac_rx_fr_err(mac_rx_fr_err), .clr(clr), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_data(rd_data), .err_sticky(err_sticky), .err_det(err_det)
    );

    // Narrow-counter instance; 1-byte frames count as good so saturation is reached quickly.
    mac_rx_monitor #(.CNT_WIDTH(8), .MIN_FRAME(1)) u_dut8 (
        .clk(clk), .rst(rst), .mac_rx_data(mac_rx_data), .mac_rx_valid(mac_rx_valid),
        .mac_rx_sof(mac_rx_sof), .mac_rx_eof(mac_rx_eof), .mac_rx_fr_good(mac_rx_fr_good),
        .mac_rx_fr_err(mac_rx_fr_err), .clr(clr), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_data(rd_data8), .err_sticky(err_sticky8), .err_det(err_det8)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd_q;
    logic        exp_det_q;

    // Model: unbounded counts, saturated only when read.
    bit     m_open   [CH];
    int     m_len    [CH];
    bit     m_bad    [CH];
    bit     m_sticky [CH];
    longint m_cnt    [CH][6];

    typedef struct { int ch; int sel; logic [31:0] exp; } vec_t;
    vec_t tbl[32];
    int exp_tab [4][8] = '{'{1, 0,   64, 0, 0, 0, 0, 0},
                           '{0, 1,  100, 0, 0, 0, 2, 0},
                           '{1, 1,   84, 1, 0, 2, 2, 0},
                           '{0, 2, 1520, 1, 1, 0, 2, 0}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void m_clear();
        for (int c = 0; c < CH; c++) begin
            m_open[c] = 0; m_len[c] = 0; m_bad[c] = 0; m_sticky[c] = 0;
            for (int k = 0; k < 6; k++) m_cnt[c][k] = 0;
        end
    endfunction

    function automatic bit m_close(int c, int len, bit fcs_ok);
        int l;
        bit good;
        l = (len > 65535) ? 65535 : len;
        good = fcs_ok && (l >= 64) && (l <= 1518);
        m_cnt[c][2] += l;
        if (l < 64) m_cnt[c][3]++;
        if (l > 1518) m_cnt[c][4]++;
        if (good) m_cnt[c][0]++;
        else begin m_cnt[c][1]++; m_sticky[c] = 1; end
        return !good;
    endfunction

    function automatic bit m_beat(int c, bit v, bit s, bit e, bit fg, bit fe);
        bit ev = 0;
        if (m_open[c] && v && s) begin
            m_cnt[c][5]++; m_sticky[c] = 1; ev = 1;
            ev |= m_close(c, m_len[c], 0);
            m_open[c] = 0;
        end
        if (!m_open[c]) begin
            if (v && s) begin
                m_open[c] = 1; m_len[c] = 1; m_bad[c] = fe;
                if (e) begin ev |= m_close(c, 1, fg && !fe); m_open[c] = 0; end
            end else if (v && e) begin
                m_cnt[c][5]++; m_sticky[c] = 1; ev = 1;
            end
        end else begin
            if (v) m_len[c]++;
            if (fe) m_bad[c] = 1;
            if (v && e) begin ev |= m_close(c, m_len[c], fg && !m_bad[c]); m_open[c] = 0; end
        end
        return ev;
    endfunction

    function automatic logic [31:0] m_read(int ch, int sel);
        if (ch >= CH) return 32'd0;
        if (sel <= 5) return (m_cnt[ch][sel] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_cnt[ch][sel]);
        if (sel == 6) return {30'd0, m_sticky[ch], m_open[ch]};
        return 32'd0;
    endfunction

    function automatic logic [CH-1:0] m_sticky_vec();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_sticky[c];
        return v;
    endfunction

    // Advance one clock: predict from the pre-edge model, then sample 1 ns after the edge.
    task automatic tick();
        logic [31:0] exp_rd;
        bit ev = 0;
        exp_rd = m_read(int'(rd_ch), int'(rd_sel));
        for (int c = 0; c < CH; c++)
            ev |= m_beat(c, mac_rx_valid[c], mac_rx_sof[c], mac_rx_eof[c],
                         mac_rx_fr_good[c], mac_rx_fr_err[c]);
        if (rst || clr) begin m_clear(); ev = 0; end
        if (rst) exp_rd = 32'd0;
        @(posedge clk);
        #1;
        exp_rd_q  = exp_rd;
        exp_det_q = ev;
    endtask

    task automatic idle_in();
        mac_rx_valid = '0; mac_rx_sof = '0; mac_rx_eof = '0;
        mac_rx_fr_good = '0; mac_rx_fr_err = '0; clr = 1'b0; rst = 1'b0;
    endtask

    task automatic beat(input int c, input bit s, input bit e, input bit fg, input bit fe);
        idle_in();
        mac_rx_valid[c] = 1'b1; mac_rx_sof[c] = s; mac_rx_eof[c] = e;
        mac_rx_fr_good[c] = fg; mac_rx_fr_err[c] = fe;
        mac_rx_data[c*8 +: 8] = 8'($urandom);
        tick();
    endtask

    task automatic frame(input int c, input int len, input int fe_at, input bit fg);
        for (int i = 0; i < len; i++) beat(c, i == 0, i == len - 1, fg, i == fe_at);
    endtask

    task automatic rd(input int ch, input int sel);
        idle_in();
        rd_ch = 2'(ch); rd_sel = 3'(sel);
        tick();
    endtask

    int  rem  [CH];
    bit  busy [CH];

    task automatic start_frame(input int c);
        int r, len;
        r = $urandom_range(0, 19);
        if (r < 8) len = $urandom_range(1, 63);
        else if (r < 19) len = $urandom_range(64, 160);
        else len = $urandom_range(1400, 1600);
        mac_rx_sof[c] = 1'b1;
        rem[c] = len - 1;
        mac_rx_eof[c] = (rem[c] == 0);
        busy[c] = (rem[c] != 0);
    endtask

    initial begin
        mac_rx_data = '0; rd_ch = '0; rd_sel = '0;
        idle_in();
        m_clear();
        for (int i = 0; i < 32; i++) begin
            tbl[i].ch  = i / 8;
            tbl[i].sel = i % 8;
            tbl[i].exp = 32'(exp_tab[i / 8][i % 8]);
        end

        rst = 1'b1; tick(); rst = 1'b1; tick();
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_err_det", {31'd0, err_det}, 32'd0);
        check("rst_sticky", {28'd0, err_sticky}, 32'd0);

        frame(0, 64, -1, 1'b1);
        check("t1_det_at_eof", {31'd0, err_det}, 32'd0);
        frame(1, 100, 50, 1'b1);
        check("t2_det_pulse", {31'd0, err_det}, 32'd1);
        idle_in(); tick();
        check("t2_det_drop", {31'd0, err_det}, 32'd0);
        check("t2_sticky", {28'd0, err_sticky}, 32'h2);
        for (int i = 0; i < 20; i++) beat(2, i == 0, 1'b0, 1'b1, 1'b0);
        beat(2, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t3_sof_in_frame_det", {31'd0, err_det}, 32'd1);
        for (int i = 1; i < 64; i++) beat(2, 1'b0, i == 63, 1'b1, 1'b0);
        beat(2, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t3_stray_eof_det", {31'd0, err_det}, 32'd1);
        frame(3, 1519, -1, 1'b1);
        frame(3, 1, -1, 1'b1);

        for (int i = 0; i < 32; i++) begin
            rd(tbl[i].ch, tbl[i].sel);
            check($sformatf("tbl_ch%0d_sel%0d", tbl[i].ch, tbl[i].sel), rd_data, tbl[i].exp);
        end
        check("t4_sticky", {28'd0, err_sticky}, 32'he);

        idle_in(); clr = 1'b1; tick();
        check("clr_sticky", {28'd0, err_sticky}, 32'd0);
        for (int i = 0; i < 300; i++) beat(0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t5_det8", {31'd0, err_det8}, 32'd0);
        check("t5_sticky8", {28'd0, err_sticky8}, 32'd0);
        rd(0, 0); check("t5_good8_sat", {24'd0, rd_data8}, 32'd255);
        rd(0, 2); check("t5_bytes8_sat", {24'd0, rd_data8}, 32'd255);
        rd(0, 1); check("t5_bad32", rd_data, 32'd300);
        for (int i = 0; i < 63; i++) beat(0, i == 0, 1'b0, 1'b1, 1'b0);
        idle_in();
        mac_rx_valid[0] = 1'b1; mac_rx_eof[0] = 1'b1; mac_rx_fr_good[0] = 1'b1; clr = 1'b1;
        tick();
        for (int s = 0; s < 7; s++) begin
            rd(0, s);
            check($sformatf("t5_clr_eof_sel%0d", s), rd_data, 32'd0);
            if (s == 0) check("t5_clr_eof_good8", {24'd0, rd_data8}, 32'd0);
        end

        for (int i = 0; i < 11; i++) beat(1, i == 0, 1'b0, 1'b1, 1'b0);
        idle_in(); rst = 1'b1; tick();
        for (int s = 0; s < 7; s++) begin
            rd(1, s);
            check($sformatf("t6_rst_sel%0d", s), rd_data, 32'd0);
        end
        beat(1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t6_post_rst_eof_det", {31'd0, err_det}, 32'd1);
        rd(1, 5); check("t6_post_rst_seq", rd_data, 32'd1);

        for (int c = 0; c < CH; c++) begin rem[c] = 0; busy[c] = 0; end
        for (int n = 0; n < 4000; n++) begin
            idle_in();
            rst = (n == 2000);
            clr = ($urandom_range(0, 999) == 0);
            rd_ch = 2'($urandom_range(0, 3));
            rd_sel = 3'($urandom_range(0, 7));
            for (int c = 0; c < CH; c++) begin
                mac_rx_fr_err[c]  = ($urandom_range(0, 299) == 0);
                mac_rx_fr_good[c] = ($urandom_range(0, 9) != 0);
                mac_rx_data[c*8 +: 8] = 8'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    mac_rx_valid[c] = 1'b1;
                    if (busy[c]) begin
                        if ($urandom_range(0, 199) == 0) start_frame(c);
                        else begin
                            rem[c]--;
                            mac_rx_eof[c] = (rem[c] == 0);
                            busy[c] = (rem[c] != 0);
                        end
                    end else begin
                        int r;
                        r = $urandom_range(0, 9);
                        if (r < 5) start_frame(c);
                        else if (r == 5) mac_rx_eof[c] = 1'b1;
                    end
                end
            end
            tick();
            check("rnd_err_det", {31'd0, err_det}, {31'd0, exp_det_q});
            check("rnd_sticky", {28'd0, err_sticky}, {28'd0, m_sticky_vec()});
            check("rnd_rd_data", rd_data, exp_rd_q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
